// File: rtl/clk_to_latch_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_to_latch_tx_pkg
//  Description : Shared constants for the clocked-to-latch transmitter:
//                default parameter values and the handshake FSM state
//                encoding (IDLE / SETUP / REQ_HI / REQ_LO).
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_to_latch_tx_pkg;

    // Default parameter values for clk_to_latch_tx
    localparam int c_DEF_WIDTH     = 32;
    localparam int c_DEF_DEPTH     = 4;
    localparam int c_DEF_SETUP_CYC = 1;

    // Handshake FSM state encoding
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam logic [1:0] c_IDLE   = 2'd0;  // waiting for a word and ack low
    localparam logic [1:0] c_SETUP  = 2'd1;  // dout loaded, counting setup time
    localparam logic [1:0] c_REQ_HI = 2'd2;  // req high, waiting for ack high
    localparam logic [1:0] c_REQ_LO = 2'd3;  // req low, waiting for ack low

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous level
//                (handshake acknowledges crossing into clk).
//  Ports       : clk - destination clock, rising edge
//                rst - asynchronous active-high reset, clears both flops
//                d   - asynchronous input level
//                q   - synchronized level, two clk edges of latency
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/clk_to_latch_tx.sv
`default_nettype none
// ============================================================================
//  Module      : clk_to_latch_tx
//  Description : Buffers words from a clocked valid/ready stream in a small
//                flop FIFO and hands them one at a time to an asynchronous
//                latch controller over a 4-phase bundled-data handshake.
//  Ports       : clk, rst          - clock (rising edge), async active-high reset
//                in_valid/in_ready - upstream handshake
//                in_data           - upstream word
//                req               - 4-phase request to the latch controller
//                ack_async         - 4-phase acknowledge, asynchronous to clk
//                dout              - bundled data to the latch
//                count             - FIFO occupancy
//                busy              - handshake FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_to_latch_tx
    import clk_to_latch_tx_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int SETUP_CYC = c_DEF_SETUP_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       req,
    input  logic                       ack_async,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_SC_W  = $clog2(SETUP_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               r_in_ready;

    state_t             r_state;
    logic [c_SC_W-1:0]  r_setup_cnt;
    logic               r_req;
    logic [WIDTH-1:0]   r_dout;

    logic               w_ack_s;
    logic               w_push;
    logic               w_pop;
    logic               w_load;

    // The acknowledge is only ever observed through this synchronizer
    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_async),
        .q   (w_ack_s)
    );

    assign w_push = in_valid & r_in_ready;
    // Head word leaves the FIFO when the receiver acknowledges it
    assign w_pop  = (r_state == c_REQ_HI) & w_ack_s;
    // A new transfer starts only once the previous ack has fully returned low
    assign w_load = (r_state == c_IDLE) & (r_count != '0) & ~w_ack_s;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping. in_ready is registered from the next occupancy so
    // that it reads 0 throughout reset and has no path from ack_async.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != c_FULL);
        end
    end

    // Storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    // ------------------------------------------------------------------
    // 4-phase handshake FSM. dout is loaded only on IDLE->SETUP, so it is
    // held for the whole handshake and while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_setup_cnt <= '0;
            r_req       <= 1'b0;
            r_dout      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_load) begin
                        r_state     <= c_SETUP;
                        r_dout      <= r_mem[r_rd_ptr];
                        r_setup_cnt <= c_SC_W'(SETUP_CYC - 1);
                    end
                end
                c_SETUP: begin
                    if (r_setup_cnt == '0) begin
                        r_state <= c_REQ_HI;
                        r_req   <= 1'b1;
                    end else begin
                        r_setup_cnt <= r_setup_cnt - c_SC_W'(1);
                    end
                end
                c_REQ_HI: begin
                    if (w_ack_s) begin
                        r_state <= c_REQ_LO;
                        r_req   <= 1'b0;
                    end
                end
                c_REQ_LO: begin
                    if (!w_ack_s) r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign count    = r_count;
    assign req      = r_req;
    assign dout     = r_dout;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_to_latch_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_to_latch_tx
//  Description : Self-checking bench for clk_to_latch_tx. A behavioural
//                latch-controller model answers req with ack_async; words
//                sent upstream are compared in order against words seen on
//                dout at each req rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_to_latch_tx;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int SETUP_CYC = 1;
    localparam int CW        = $clog2(DEPTH + 1);

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic             in_ready;
    logic             req;
    logic             ack_async;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             busy;

    logic ack_man  = 1'b0;
    logic ack_auto = 1'b0;
    logic auto_en  = 1'b0;
    assign ack_async = auto_en ? ack_auto : ack_man;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sent_q[$];
    logic [WIDTH-1:0] got_q[$];

    logic             mon_prev_req  = 1'b0;
    logic [WIDTH-1:0] mon_prev_dout = '0;
    logic [WIDTH-1:0] mon_rise_dout = '0;
    int               mon_stable    = 0;
    int               resp_dly      = 0;

    always #5 clk = ~clk;

    clk_to_latch_tx #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .SETUP_CYC (SETUP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .ack_async (ack_async),
        .dout      (dout),
        .count     (count),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        if (n < 300) sent_q.push_back(w);
    endtask

    task automatic wait_req(input logic v, input int lim, input string tag);
        int n = 0;
        while (req !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, req, v);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        auto_en = 1'b1;
        while (!(count == '0 && busy == 1'b0 && got_q.size() == sent_q.size()) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_done"}, 64'(n < 3000), 64'd1);
        chk({tag, "_n_words"}, 64'(got_q.size()), 64'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
            chk({tag, "_word_order"}, got_q[i], sent_q[i]);
        sent_q.delete();
        got_q.delete();
        auto_en = 1'b0;
    endtask

    // Behavioural latch controller: follows req after a random delay
    initial begin : ack_responder
        forever begin
            @(negedge clk);
            if (rst || !auto_en) begin
                ack_auto = 1'b0;
                resp_dly = 0;
            end else if (req !== ack_auto) begin
                if (resp_dly == 0) begin
                    ack_auto = req;
                    resp_dly = int'($urandom_range(0, 4));
                end else begin
                    resp_dly--;
                end
            end
        end
    end

    // Protocol monitor and receive-side capture, sampled after each rising edge
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_prev_req  = 1'b0;
                mon_prev_dout = dout;
                mon_stable    = 0;
            end else begin
                if (dout !== mon_prev_dout) mon_stable = 0;
                else mon_stable++;
                if (req && !mon_prev_req) begin
                    chk("setup_before_req", 64'(mon_stable >= SETUP_CYC), 64'd1);
                    chk("ack_low_at_req_rise", ack_async, 1'b0);
                    got_q.push_back(dout);
                    mon_rise_dout = dout;
                end
                if (!req && mon_prev_req) begin
                    chk("ack_high_at_req_fall", ack_async, 1'b1);
                    chk("dout_held_in_handshake", dout, mon_rise_dout);
                end
                mon_prev_req  = req;
                mon_prev_dout = dout;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [WIDTH-1:0] w_a, w_b, w_c, rec;

        // ---------------- reset state ----------------
        tick(3);
        chk("rst_req", req, 1'b0);
        chk("rst_count", count, '0);
        chk("rst_dout", dout, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        chk("in_ready_before_edge", in_ready, 1'b0);
        tick(1);
        chk("in_ready_after_edge", in_ready, 1'b1);

        // ---------------- single word, ack after 3 cycles ----------------
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        tick(1);
        in_valid = 1'b0;
        sent_q.push_back(32'hDEADBEEF);
        chk("single_count_1", count, 3'd1);
        chk("single_idle_after_push", busy, 1'b0);
        tick(1);
        chk("single_setup_busy", busy, 1'b1);
        chk("single_dout_loaded", dout, 32'hDEADBEEF);
        chk("single_req_low_in_setup", req, 1'b0);
        tick(1);
        chk("single_req_high", req, 1'b1);
        tick(3);
        ack_man = 1'b1;
        wait_req(1'b0, 10, "single_req_fall");
        chk("single_count_0", count, '0);
        ack_man = 1'b0;
        drain("single");

        // ---------------- fill and drain, ack held low ----------------
        for (int i = 1; i <= 4; i++) push(WIDTH'(i));
        tick(2);
        chk("fill_count_full", count, 3'd4);
        chk("fill_in_ready_low", in_ready, 1'b0);
        chk("fill_req_high", req, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd5;
        tick(3);
        chk("fill_fifth_held_count", count, 3'd4);
        chk("fill_fifth_held_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        auto_en  = 1'b1;
        push(32'd5);
        drain("fill");

        // ---------------- simultaneous push and pop ----------------
        w_a = $urandom;
        w_b = $urandom;
        w_c = $urandom;
        push(w_a);
        wait_req(1'b1, 20, "simul_req_rise");
        push(w_b);
        chk("simul_count_2", count, 3'd2);
        ack_man = 1'b1;
        tick(2);
        in_valid = 1'b1;
        in_data  = w_c;
        tick(1);
        in_valid = 1'b0;
        sent_q.push_back(w_c);
        chk("simul_count_stays_2", count, 3'd2);
        chk("simul_req_dropped", req, 1'b0);
        ack_man = 1'b0;
        drain("simul");

        // ---------------- slow ack ----------------
        w_a = $urandom;
        w_b = $urandom;
        push(w_a);
        push(w_b);
        wait_req(1'b1, 20, "slow_req_rise");
        rec = dout;
        chk("slow_dout_first_word", rec, w_a);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("slow_req_held", req, 1'b1);
            chk("slow_dout_stable", dout, rec);
        end
        ack_man = 1'b1;
        wait_req(1'b0, 10, "slow_req_fall");
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("slow_no_req_while_ack_high", req, 1'b0);
        end
        ack_man = 1'b0;
        drain("slow");

        // ---------------- reset in the middle of REQ_HI ----------------
        w_a = $urandom | 32'h1;
        push(w_a);
        wait_req(1'b1, 20, "midrst_req_rise");
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req", req, 1'b0);
        chk("midrst_count", count, '0);
        chk("midrst_dout", dout, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready_held", in_ready, 1'b0);
        tick(1);
        chk("midrst_in_ready_back", in_ready, 1'b1);
        sent_q.delete();
        got_q.delete();

        // ---------------- integration: random words, random ack delays ----------------
        auto_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(int'($urandom_range(0, 3)));
            push($urandom);
        end
        drain("random");

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
